// File: rtl/apb_completer_regfile.sv
`timescale 1ns/1ps
// APB3/APB4 completer fronting a small byte-strobed register file with PSLVERR on bad accesses.
// Latency: setup + (WAIT_CYCLES+1) access cycles; stalls the requester by holding pready low during wait states.
module apb_completer_regfile #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0,
    parameter int                         NUM_WORDS     = 8,
    parameter int                         WAIT_CYCLES   = 0,
    parameter bit                         PROT_CHECK    = 1'b1
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [ADDRESS_WIDTH-1:0]      paddr,
    input  logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH/8-1:0]       pstrb,
    input  logic [2:0]                    pprot,
    output logic                          pready,
    output logic                          pslverr,
    output logic [DATA_WIDTH-1:0]         prdata
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // One extra bit so the window end never wraps at the top of the address space.
    localparam logic [ADDRESS_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDRESS_WIDTH:0] WIN_HI = {1'b0, BASE_ADDR} + (ADDRESS_WIDTH+1)'(4 * NUM_WORDS);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic                     write;
        logic [DATA_WIDTH-1:0]    wdata;
        logic [NUM_BYTES-1:0]     strb;
        logic [2:0]               prot;
    } req_t;

    state_t                   state, state_nxt;
    logic [3:0]               wcnt, wcnt_nxt;
    req_t                     req_q;
    logic                     capture;
    logic                     commit;
    logic                     err;
    logic                     in_win;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic [IDX_W-1:0]         index;
    logic [DATA_WIDTH-1:0]    mem [NUM_WORDS];

    assign in_win = ({1'b0, req_q.addr} >= WIN_LO) && ({1'b0, req_q.addr} < WIN_HI);
    assign err    = !in_win
                 || (req_q.addr[1:0] != 2'b00)
                 || (PROT_CHECK && req_q.write && !req_q.prot[0]);
    assign offset = req_q.addr - BASE_ADDR;
    assign index  = offset[IDX_W+1:2];

    logic unused_bits;
    assign unused_bits = ^{req_q.prot[2:1], offset};

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        capture   = 1'b0;
        commit    = 1'b0;
        // A setup phase always wins, even mid-transfer: the old transfer is dropped unwritten.
        if (psel && !penable) begin
            capture   = 1'b1;
            state_nxt = ACCESS;
            wcnt_nxt  = 4'(WAIT_CYCLES);
        end else if (state == ACCESS) begin
            if (!psel) begin
                state_nxt = IDLE;
            end else if (wcnt != 4'd0) begin
                wcnt_nxt = wcnt - 4'd1;
            end else begin
                state_nxt = IDLE;
                commit    = req_q.write && !err;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
            wcnt  <= 4'd0;
            req_q <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (capture) begin
                req_q.addr  <= paddr;
                req_q.write <= pwrite;
                req_q.wdata <= pwdata;
                req_q.strb  <= pstrb;
                req_q.prot  <= pprot;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (req_q.strb[b]) begin
                    mem[index][8*b +: 8] <= req_q.wdata[8*b +: 8];
                end
            end
        end
    end

    assign pready  = (state == ACCESS) && (wcnt == 4'd0);
    assign pslverr = pready && err;
    assign prdata  = (pready && !req_q.write && !err) ? mem[index] : '0;

endmodule

// File: tb/tb_apb_completer_regfile.sv
`timescale 1ns/1ps
// Directed and randomized APB transfers against two completers (zero-wait at base 0, three-wait at base 0x100),
// each checked against a byte-array reference model of the register window.
module tb_apb_completer_regfile;

    localparam int NW = 8;
    localparam int W_A = 0;
    localparam int W_B = 3;
    localparam logic [31:0] BASE_B = 32'h100;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel_a = 1'b0, psel_b = 1'b0;
    logic        penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;
    logic [31:0] prdata_a, prdata_b;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [2][NW];

    always #5 pclk = ~pclk;

    apb_completer_regfile #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0),
        .NUM_WORDS(NW), .WAIT_CYCLES(W_A), .PROT_CHECK(1'b1)
    ) u_dut_a (
        .pclk(pclk), .preset_n(preset_n), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready_a), .pslverr(pslverr_a), .prdata(prdata_a)
    );

    apb_completer_regfile #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE_B),
        .NUM_WORDS(NW), .WAIT_CYCLES(W_B), .PROT_CHECK(1'b1)
    ) u_dut_b (
        .pclk(pclk), .preset_n(preset_n), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready_b), .pslverr(pslverr_b), .prdata(prdata_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned base_of(input int d);
        return (d == 0) ? 64'h0 : 64'(BASE_B);
    endfunction

    function automatic logic model_err(input int d, input logic wr, input logic [31:0] addr,
                                       input logic [2:0] prot);
        longint unsigned a, lo, hi;
        a  = 64'(addr);
        lo = base_of(d);
        hi = lo + 64'(4 * NW);
        return (a < lo) || (a >= hi) || (addr[1:0] != 2'b00) || (wr && !prot[0]);
    endfunction

    function automatic int model_idx(input int d, input logic [31:0] addr);
        return int'((64'(addr) - base_of(d)) / 4);
    endfunction

    task automatic set_sel(input int d, input logic v);
        if (d == 0) psel_a = v;
        else        psel_b = v;
    endtask

    function automatic logic cur_rdy(input int d);
        return (d == 0) ? pready_a : pready_b;
    endfunction

    function automatic logic cur_err(input int d);
        return (d == 0) ? pslverr_a : pslverr_b;
    endfunction

    function automatic logic [31:0] cur_rd(input int d);
        return (d == 0) ? prdata_a : prdata_b;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < NW; w++)
                model[d][w] = '0;
    endtask

    // Full transfer: setup, access until pready, then release the bus.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input string tag);
        logic        exp_err, done, got_err;
        logic [31:0] exp_rd, got_rd;
        int          waits;
        exp_err = model_err(d, wr, addr, prot);
        exp_rd  = (!wr && !exp_err) ? model[d][model_idx(d, addr)] : 32'h0;
        @(posedge pclk); #1;
        set_sel(d, 1'b1);
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0; done = 1'b0; got_err = 1'b0; got_rd = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge pclk);
            if (cur_rdy(d)) begin
                done    = 1'b1;
                got_err = cur_err(d);
                got_rd  = cur_rd(d);
            end else begin
                waits++;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_waits"}, 32'(waits), (d == 0) ? 32'(W_A) : 32'(W_B));
        chk({tag, "_pslverr"}, 32'(got_err), 32'(exp_err));
        chk({tag, "_prdata"}, got_rd, exp_rd);
        if (done && wr && !exp_err)
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[d][model_idx(d, addr)][8*b +: 8] = wdata[8*b +: 8];
        @(posedge pclk); #1;
        set_sel(d, 1'b0);
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        int          d;
        clear_model();
        #12;
        chk("rst_pready_a", 32'(pready_a), 32'd0);
        chk("rst_pslverr_b", 32'(pslverr_b), 32'd0);
        chk("rst_prdata_a", prdata_a, 32'h0);
        @(posedge pclk); #1;
        preset_n = 1'b1;

        // Zero-wait write then read, byte strobes, errors.
        xfer(0, 1, 32'h8, 32'hDEAD_BEEF, 4'hF, 3'b001, "wr_8");
        xfer(0, 0, 32'h8, 32'h0, 4'h0, 3'b000, "rd_8");
        xfer(0, 1, 32'h4, 32'h1122_3344, 4'hF, 3'b001, "wr_4");
        xfer(0, 1, 32'h4, 32'hAABB_CCDD, 4'b0101, 3'b001, "wr_4_strb");
        xfer(0, 0, 32'h4, 32'h0, 4'hF, 3'b001, "rd_4_strb");
        chk("strb_merge", prdata_a, 32'h0);
        xfer(0, 1, 32'h20, 32'h5555_5555, 4'hF, 3'b001, "err_oow");
        xfer(0, 0, 32'h6, 32'h0, 4'hF, 3'b001, "err_misalign");
        xfer(0, 1, 32'h0, 32'h7777_7777, 4'hF, 3'b000, "err_prot");
        xfer(0, 1, 32'hFFFF_FFFC, 32'h6666_6666, 4'hF, 3'b001, "err_top");
        xfer(0, 1, 32'h8, 32'h1234_5678, 4'h0, 3'b001, "wr_nostrb");
        xfer(0, 0, 32'h8, 32'h0, 4'h0, 3'b000, "rd_8_after");
        xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b000, "rd_0_after_err");
        xfer(0, 0, 32'h1C, 32'h0, 4'h0, 3'b000, "rd_last_a");

        // Three-wait completer at a non-zero base.
        xfer(1, 0, 32'h100, 32'h0, 4'h0, 3'b000, "b_rd_base");
        xfer(1, 1, 32'h11C, 32'hCAFE_F00D, 4'hF, 3'b011, "b_wr_last");
        xfer(1, 0, 32'h11C, 32'h0, 4'h0, 3'b000, "b_rd_last");
        xfer(1, 1, 32'hFC, 32'h1, 4'hF, 3'b001, "b_err_below");
        xfer(1, 1, 32'h120, 32'h2, 4'hF, 3'b001, "b_err_above");
        xfer(1, 1, 32'h104, 32'h0BAD_0BAD, 4'hF, 3'b001, "b_wr_104");

        // Abort by dropping psel during wait states.
        @(posedge pclk); #1;
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h104;
        pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("abort_wait_rdy", 32'(pready_b), 32'd0);
        @(posedge pclk); #1;
        psel_b = 1'b0; penable = 1'b0;
        xfer(1, 0, 32'h104, 32'h0, 4'h0, 3'b000, "abort_drop_rd");

        // Abort by a fresh setup while still waiting.
        @(posedge pclk); #1;
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h104;
        pwdata = 32'hEEEE_EEEE; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        xfer(1, 0, 32'h104, 32'h0, 4'h0, 3'b000, "abort_resetup_rd");

        // penable without a setup phase is ignored.
        @(posedge pclk); #1;
        psel_a = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("idle_penable_rdy", 32'(pready_a), 32'd0);
        end
        @(posedge pclk); #1;
        psel_a = 1'b0; penable = 1'b0;

        // Randomized traffic on both completers.
        for (int i = 0; i < 60; i++) begin
            d  = int'($urandom_range(0, 1));
            ra = 32'(base_of(d)) + 32'($urandom_range(0, 4 * NW + 7)) - 32'd4;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            xfer(d, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom),
                 ($urandom_range(0, 4) == 0) ? 3'b000 : 3'b001, "rand");
        end

        // Asynchronous reset during a completing access.
        @(posedge pclk); #1;
        psel_a = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        chk("pre_reset_rdy", 32'(pready_a), 32'd1);
        preset_n = 1'b0;
        #1;
        chk("async_rst_rdy", 32'(pready_a), 32'd0);
        chk("async_rst_prdata", prdata_a, 32'h0);
        chk("async_rst_err", 32'(pslverr_a), 32'd0);
        @(posedge pclk); #1;
        psel_a = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset_n = 1'b1;
        clear_model();
        for (int w = 0; w < NW; w++) begin
            xfer(0, 0, 32'(4 * w), 32'h0, 4'h0, 3'b000, "post_rst_a");
            xfer(1, 0, BASE_B + 32'(4 * w), 32'h0, 4'h0, 3'b000, "post_rst_b");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_completer_regfile.md
# apb_completer_regfile

Synthesizable APB3/APB4 completer (slave) that answers the requests driven by the APB master agent. It decodes one address window, holds a small byte-strobed register file and inserts a fixed number of wait states per transfer. It flags bad accesses with PSLVERR. The block is the RTL DUT the master agent drives: one instance sits behind each PSELx line of the slave_no_e one-hot select.

## Interface
- ADDRESS_WIDTH, 32, width of paddr
- DATA_WIDTH, 32, width of pwdata/prdata; only 32 is supported
- BASE_ADDR, 0, byte address of word 0; must be 4-byte aligned
- NUM_WORDS, 8, register-file depth in 32-bit words; the window is BASE_ADDR to BASE_ADDR+4*NUM_WORDS-1, which is bytes 0..31 by default
- WAIT_CYCLES, 0, wait states per transfer, range 0..15
- PROT_CHECK, 1, when 1 a write with pprot[0]=0 (unprivileged) is an error
- Reset and clocking (already decided): one clock; reset is asynchronous and active-low.
- pclk, input, 1, clock; all state changes on the rising edge
- preset_n, input, 1, asynchronous active-low reset
- psel, input, 1, this completer's PSELx
- penable, input, 1, access phase indicator
- pwrite, input, 1, 1=WRITE, 0=READ
- paddr, input, ADDRESS_WIDTH, byte address
- pwdata, input, DATA_WIDTH, write data
- pstrb, input, DATA_WIDTH/8, write byte-lane strobes
- pprot, input, 3, protection attributes
- pready, output, 1, transfer completes in this cycle
- pslverr, output, 1, transfer error; valid only while pready=1
- prdata, output, DATA_WIDTH, read data; valid only while pready=1

## Operation
- The FSM has two states, IDLE and ACCESS, plus a 4-bit wait counter wcnt.
- Setup capture: at any rising edge with psel=1 and penable=0, the block
  - captures paddr, pwrite, pwdata, pstrb and pprot;
  - loads wcnt=WAIT_CYCLES;
  - moves to ACCESS.
- This capture applies in both IDLE and ACCESS. In ACCESS it aborts the current transfer with no write and starts the new one.
- ACCESS:
  - If psel=1 and penable=1 and wcnt≠0, wcnt decrements by one each edge.
  - If psel=1 and penable=1 and wcnt=0, the transfer completes at that edge and the FSM returns to IDLE.
  - If psel=0, the transfer is aborted: return to IDLE, no write.
- Error conditions (err, evaluated on the captured fields):
  - The address lies outside the window. Compare at full ADDRESS_WIDTH with no truncation.
  - addr[1:0]≠0.
  - PROT_CHECK=1 and pwrite=1 and pprot[0]=0.
- Index = (addr − BASE_ADDR) >> 2, used only when err=0.
- Write commit happens at the completing edge and only when err=0. For each i with pstrb[i]=1, mem[index] byte i takes pwdata byte i. pstrb=0 is a legal no-op with pslverr=0.
- Reads ignore pstrb and pprot, and have no side effects.

## Timing
- Outputs are combinational from the registered state:
  - pready = (state==ACCESS) && (wcnt==0).
  - pslverr = pready && err.
  - prdata = mem[index] when pready=1, pwrite=0 and err=0; otherwise all zeros.
- Zero-wait transfer: setup cycle T0, access cycle T1 with pready=1, complete at the end of T1. Each wait state adds exactly one cycle of pready=0.
- Back-to-back transfers: a setup phase may directly follow a completing access. Throughput is 2+WAIT_CYCLES cycles per transfer.
- A write is visible to a read whose setup follows the write's completing edge.
- Reset (preset_n=0, asynchronous):
  - state=IDLE, wcnt=0, captured fields=0;
  - all NUM_WORDS words cleared to 0;
  - pready=0, pslverr=0, prdata=0 immediately.
- Reset mid-transfer discards the transfer with no write. The first setup sampled after deassertion starts cleanly.
- In IDLE, pready, pslverr and prdata are 0 regardless of inputs. penable=1 with state=IDLE (a protocol violation) is ignored.

## Test plan
- Write then read, zero wait, BASE_ADDR=0. Write 0x0000_0008 ← 0xDEAD_BEEF with pstrb=4'hF. Read 0x8 → prdata=0xDEAD_BEEF, pready=1 in the first access cycle, pslverr=0.
- Byte strobes. Start with word 0x4=0x1122_3344. Write 0xAABB_CCDD with pstrb=4'b0101. Read back → 0x11BB_33DD.
- Wait states. With WAIT_CYCLES=3, a read of 0x0 → pready low for exactly 3 access cycles and high in the 4th. The transfer takes 5 cycles in total.
- Errors, all with pslverr=1 at completion, no memory change and prdata=0:
  - write to 0x20 (out of window, NUM_WORDS=8);
  - read of 0x6 (misaligned);
  - write to 0x0 with pprot=3'b000.
- Abort and reset. With WAIT_CYCLES=2:
  - drop psel during wait → later read of the same address returns the old value;
  - assert preset_n=0 mid-access → pready=0 asynchronously and all words read 0 afterwards.
